// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, async imem interface, and a DEPTH-entry
// instruction buffer with valid/ready handshake to decode. Optional macro: FETCH_FAULT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned IMEM_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    output logic        o_fetch_fault
);

    localparam int unsigned           PTR_W    = $clog2(DEPTH);
    localparam int unsigned           CNT_W    = PTR_W + 1;
    localparam logic [31:0]           NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);

    logic [31:0]      fpc;
    logic [31:0]      buf_instr [DEPTH];
    logic [31:0]      buf_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             halted;
    logic             pc_fault;
    logic             push;
    logic             pop;

    assign o_imem_addr   = fpc;
    assign o_instr_valid = (count != '0);
    assign o_instr       = o_instr_valid ? buf_instr[rd_ptr] : NOP;
    assign o_instr_pc    = o_instr_valid ? buf_pc[rd_ptr]    : '0;

    assign pop  = o_instr_valid && i_instr_ready;
    assign push = !i_redirect_valid && !halted && !pc_fault && ((count < FULL_CNT) || pop);

`ifdef FETCH_FAULT_EN
    logic redirect_ok;

    assign pc_fault    = ({2'b00, fpc[31:2]} >= 32'(IMEM_WORDS));
    assign redirect_ok = (i_redirect_pc[1:0] == 2'b00) &&
                         ({2'b00, i_redirect_pc[31:2]} < 32'(IMEM_WORDS));

    // Only a clean redirect leaves the halted state; an out-of-range PC halts
    // fetch before it is ever pushed.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            halted <= 1'b0;
        end else if (i_redirect_valid) begin
            halted <= !redirect_ok;
        end else if (pc_fault) begin
            halted <= 1'b1;
        end
    end

    assign o_fetch_fault = halted && (count == '0);
`else
    logic unused_cfg;

    assign pc_fault      = 1'b0;
    assign halted        = 1'b0;
    assign o_fetch_fault = 1'b0;
    assign unused_cfg    = (^i_redirect_pc[1:0]) ^ (IMEM_WORDS == 0);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (i_redirect_valid) begin
            fpc    <= {i_redirect_pc[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                fpc    <= fpc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: count gates every read of the buffer.
    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= i_imem_rdata;
            buf_pc[wr_ptr]    <= fpc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: queue-based reference model of the fetch
// buffer, directed scenarios plus randomized ready/redirect traffic.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned IMEM_WORDS = 2048;
    localparam logic [31:0] NOP        = 32'h0000_0013;
`ifdef FETCH_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;
    logic        o_fetch_fault;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: ordered queue of {pc, instr}, fetch PC, halted flag.
    logic [63:0] mq [$];
    logic [31:0] m_fpc = RESET_PC;
    bit          m_halted = 1'b0;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .o_imem_addr     (o_imem_addr),
        .i_imem_rdata    (i_imem_rdata),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc),
        .o_instr_valid   (o_instr_valid),
        .o_instr         (o_instr),
        .o_instr_pc      (o_instr_pc),
        .i_instr_ready   (i_instr_ready),
        .o_fetch_fault   (o_fetch_fault)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents: word k holds value k.
    assign i_imem_rdata = {2'b00, o_imem_addr[31:2]};

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_fpc    = RESET_PC;
        m_halted = 1'b0;
    endfunction

    function automatic void model_edge();
        bit do_pop;
        bit oor;
        bit do_push;
        do_pop  = (mq.size() != 0) && i_instr_ready;
        oor     = FAULT_EN && ((m_fpc >> 2) >= IMEM_WORDS);
        do_push = !i_redirect_valid && !m_halted && !oor && ((mq.size() < DEPTH) || do_pop);
        if (i_redirect_valid) begin
            mq.delete();
            m_fpc = i_redirect_pc & ~32'h3;
            if (FAULT_EN)
                m_halted = (i_redirect_pc[1:0] != 2'b00) || ((i_redirect_pc >> 2) >= IMEM_WORDS);
        end else begin
            if (oor) m_halted = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_fpc, mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endfunction

    function automatic logic [97:0] model_vec();
        logic [63:0] h;
        h = (mq.size() != 0) ? mq[0] : {32'h0, NOP};
        return {mq.size() != 0, h[31:0], h[63:32], m_fpc, m_halted && (mq.size() == 0)};
    endfunction

    function automatic logic [97:0] dut_vec();
        return {o_instr_valid, o_instr, o_instr_pc, o_imem_addr, o_fetch_fault};
    endfunction

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        i_instr_ready    = rdy;
        i_redirect_valid = rv;
        i_redirect_pc    = rpc;
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0);
        i_reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({o_instr_valid, o_instr, o_instr_pc, o_imem_addr, o_fetch_fault} !==
            {1'b0, NOP, 32'h0, RESET_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_vec(),
                     {1'b0, NOP, 32'h0, RESET_PC, 1'b0});
        end
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b0, '0);
        i_reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if ({o_instr_valid, o_instr, o_instr_pc} !== {1'b1, 32'(k), RESET_PC + 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL stream[%0d]: got v=%b i=%h pc=%h want v=1 i=%h pc=%h", k,
                         o_instr_valid, o_instr, o_instr_pc, 32'(k), RESET_PC + 32'(4 * k));
            end
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL stream_model[%0d]: got %h want %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] next_pc;
        i_reset = 1'b1;
        tick();
        drive(1'b0, 1'b0, '0);
        i_reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_tests++;
        if ({o_instr_valid, o_instr_pc, o_imem_addr} !==
            {1'b1, RESET_PC, RESET_PC + 32'(4 * DEPTH)}) begin
            n_fail++;
            $display("FAIL stall_full: got v=%b pc=%h fpc=%h want v=1 pc=%h fpc=%h",
                     o_instr_valid, o_instr_pc, o_imem_addr, RESET_PC, RESET_PC + 32'(4 * DEPTH));
        end
        next_pc = RESET_PC;
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (!o_instr_valid || o_instr_pc !== next_pc) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: got v=%b pc=%h want v=1 pc=%h", k,
                         o_instr_valid, o_instr_pc, next_pc);
            end
            next_pc = next_pc + 32'd4;
            tick();
        end
    endtask

    task automatic test_redirect_full();
        drive(1'b0, 1'b0, '0);
        for (int k = 0; k <= DEPTH; k++) tick();
        drive(1'b0, 1'b1, 32'h100);
        tick();
        n_tests++;
        if (o_instr_valid !== 1'b0 || o_imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_flush: got v=%b fpc=%h want v=0 fpc=00000100",
                     o_instr_valid, o_imem_addr);
        end
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if ({o_instr_valid, o_instr_pc} !== {1'b1, 32'h100 + 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL redirect_target[%0d]: got v=%b pc=%h want v=1 pc=%h", k,
                         o_instr_valid, o_instr_pc, 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, 32'h200);
        tick();
        drive(1'b1, 1'b1, 32'h40);
        tick();
        drive(1'b1, 1'b1, 32'h80);
        tick();
        n_tests++;
        if (o_instr_valid !== 1'b0 || o_imem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL b2b_last_wins: got v=%b fpc=%h want v=0 fpc=00000080",
                     o_instr_valid, o_imem_addr);
        end
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if ({o_instr_valid, o_instr_pc, o_instr} !== {1'b1, 32'h80 + 32'(4 * k), 32'h20 + 32'(k)}) begin
                n_fail++;
                $display("FAIL b2b_stream[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k,
                         o_instr_valid, o_instr_pc, o_instr, 32'h80 + 32'(4 * k), 32'h20 + 32'(k));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int k = 0; k < 400; k++) begin
            tgt = 32'($urandom_range(0, 32'h1FFF));
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, tgt);
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", k, dut_vec(), model_vec());
            end
        end
        drive(1'b0, 1'b1, 32'h300);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) tick();
        #3;
        i_reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({o_instr_valid, o_instr, o_instr_pc, o_imem_addr} !== {1'b0, NOP, 32'h0, RESET_PC}) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h",
                     {o_instr_valid, o_instr, o_instr_pc, o_imem_addr}, {1'b0, NOP, 32'h0, RESET_PC});
        end
        #2;
        i_reset = 1'b0;
        tick();
        n_tests++;
        if ({o_instr_valid, o_instr_pc, o_instr} !== {1'b1, RESET_PC, mem_word(RESET_PC)}) begin
            n_fail++;
            $display("FAIL refetch_after_reset: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                     o_instr_valid, o_instr_pc, o_instr, RESET_PC, mem_word(RESET_PC));
        end
    endtask

`ifdef FETCH_FAULT_EN
    task automatic test_fault();
        logic [31:0] last_pc;
        last_pc = '0;
        drive(1'b1, 1'b1, 32'h1FF0);
        tick();
        drive(1'b1, 1'b0, '0);
        for (int k = 0; k < 10; k++) begin
            if (o_instr_valid) last_pc = o_instr_pc;
            tick();
        end
        n_tests++;
        if ({o_fetch_fault, o_instr_valid, last_pc} !== {1'b1, 1'b0, 32'h1FFC}) begin
            n_fail++;
            $display("FAIL fault_drain: got f=%b v=%b last=%h want f=1 v=0 last=00001ffc",
                     o_fetch_fault, o_instr_valid, last_pc);
        end
        drive(1'b1, 1'b1, 32'h6);
        tick();
        drive(1'b1, 1'b0, '0);
        tick();
        n_tests++;
        if ({o_fetch_fault, o_instr_valid, o_imem_addr} !== {1'b1, 1'b0, 32'h4}) begin
            n_fail++;
            $display("FAIL fault_misaligned: got f=%b v=%b fpc=%h want f=1 v=0 fpc=00000004",
                     o_fetch_fault, o_instr_valid, o_imem_addr);
        end
        drive(1'b1, 1'b1, 32'h10);
        tick();
        n_tests++;
        if ({o_fetch_fault, o_imem_addr} !== {1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL fault_clear: got f=%b fpc=%h want f=0 fpc=00000010",
                     o_fetch_fault, o_imem_addr);
        end
        drive(1'b1, 1'b0, '0);
        tick();
        n_tests++;
        if ({o_instr_valid, o_instr_pc} !== {1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL fault_resume: got v=%b pc=%h want v=1 pc=00000010",
                     o_instr_valid, o_instr_pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef FETCH_FAULT_EN
        test_fault();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
